// File: rtl/sr_fetch_unit_pkg.sv
// Shared types and defaults for the sr_cpu instruction-fetch front end.
package sr_fetch_unit_pkg;

  localparam int SR_FETCH_W     = 2;
  localparam int SR_FETCH_DEPTH = 4;

  typedef enum logic [1:0] {
    SR_FETCH_IDLE = 2'd0,
    SR_FETCH_REQ  = 2'd1,
    SR_FETCH_DROP = 2'd2
  } fetchState_e;

  // One queued instruction with the byte PC it was fetched from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ibufEntry_t;

endpackage

// File: rtl/sr_fetch_unit_ibuf.sv
// sr_ibuf: DEPTH-entry instruction queue. Accepts up to FETCH_W in-order
// entries per cycle, pops one from the head, flush clears it in one cycle.
module sr_ibuf import sr_fetch_unit_pkg::*; #(
  parameter  int FETCH_W = SR_FETCH_W,
  parameter  int DEPTH   = SR_FETCH_DEPTH,
  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int NW      = $clog2(FETCH_W + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [NW-1:0]            wrN,
  input  ibufEntry_t [FETCH_W-1:0] wrEntry,
  input  logic                     rdEn,
  output logic                     rdValid,
  output ibufEntry_t               rdEntry,
  output logic [CW-1:0]            count
);

  ibufEntry_t                 mem [DEPTH];
  logic [PW-1:0]              wrPtr, rdPtr;
  logic [FETCH_W-1:0][PW-1:0] wrIdx;
  logic                       doRd;

  assign rdValid = (count != '0);
  assign rdEntry = mem[rdPtr];
  assign doRd    = rdEn && rdValid;

  // Slot address for each write lane, wrapping modulo DEPTH
  always_comb begin
    wrIdx = '0;
    for (int i = 0; i < FETCH_W; i++)
      wrIdx[i] = PW'((int'(wrPtr) + i) % DEPTH);
  end

  // Storage write: lanes below wrN land at consecutive slots
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++)
      if (!flush && i < int'(wrN))
        mem[wrIdx[i]] <= wrEntry[i];
  end

  // Pointers and occupancy; flush wins over a same-cycle push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= PW'((int'(wrPtr) + int'(wrN)) % DEPTH);
      if (doRd) rdPtr <= PW'((int'(rdPtr) + 1) % DEPTH);
      count <= CW'(int'(count) + int'(wrN) - (doRd ? 1 : 0));
    end
  end

endmodule

// File: rtl/sr_fetch_unit.sv
// sr_fetch_unit: line fetch FSM, fetch PC, slot-offset handling and the
// decode-side handshake. Optional macro SR_FETCH_BYPASS_EN presents the
// first slot of an ack straight to decode when the queue is empty.
module sr_fetch_unit import sr_fetch_unit_pkg::*; #(
  parameter int          FETCH_W  = SR_FETCH_W,
  parameter int          DEPTH    = SR_FETCH_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imReq,
  output logic [31:0]            imAddr,
  input  logic                   imAck,
  input  logic [32*FETCH_W-1:0]  imData,
  input  logic                   redirect,
  input  logic [31:0]            redirectPc,
  output logic                   instrValid,
  output logic [31:0]            instr,
  output logic [31:0]            instrPc,
  input  logic                   instrReady
);

  localparam int          NW         = $clog2(FETCH_W + 1);
  localparam int          CW         = $clog2(DEPTH + 1);
  localparam logic [31:0] LINE_BYTES = 32'(FETCH_W * 4);
  localparam logic [31:0] LINE_MASK  = 32'(FETCH_W * 4 - 1);
  localparam logic [31:0] SLOT_MASK  = 32'(FETCH_W - 1);

  fetchState_e                state, stateNxt;
  logic [31:0]                fpc, lineByte;
  int                         off, startSlot;
  logic                       ackTake, bypass, bufValid, bufPop;
  logic [NW-1:0]              wrN;
  ibufEntry_t [FETCH_W-1:0]   wrEntry;
  ibufEntry_t                 rdEntry;
  logic [CW-1:0]              bufCount;

  assign lineByte = fpc & ~LINE_MASK;
  assign off      = int'((fpc >> 2) & SLOT_MASK);
  assign imAddr   = lineByte >> 2;
  assign ackTake  = (state == SR_FETCH_REQ) && imAck && !redirect;
  assign bufPop   = bufValid && instrReady;

`ifdef SR_FETCH_BYPASS_EN
  assign bypass = ackTake && !bufValid;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed slot that decode takes this cycle is not written to the queue
  assign startSlot = off + ((bypass && instrReady) ? 1 : 0);

  // Build the in-order write lanes from the acked line
  always_comb begin
    wrN     = '0;
    wrEntry = '0;
    if (ackTake) begin
      wrN = NW'(FETCH_W - startSlot);
      for (int i = 0; i < FETCH_W; i++)
        if (startSlot + i < FETCH_W) begin
          wrEntry[i].pc    = lineByte + 32'(4 * (startSlot + i));
          wrEntry[i].instr = imData[32*(startSlot+i) +: 32];
        end
    end
  end

  sr_ibuf #(.FETCH_W(FETCH_W), .DEPTH(DEPTH)) uIbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect),
    .wrN     (wrN),
    .wrEntry (wrEntry),
    .rdEn    (instrReady),
    .rdValid (bufValid),
    .rdEntry (rdEntry),
    .count   (bufCount)
  );

  // Next state: request while a full line fits, drain a dropped ack
  always_comb begin
    stateNxt = state;
    imReq    = 1'b0;
    case (state)
      SR_FETCH_IDLE:
        if (!redirect && (DEPTH - int'(bufCount)) >= FETCH_W)
          stateNxt = SR_FETCH_REQ;
      SR_FETCH_REQ: begin
        imReq = 1'b1;
        if (redirect)
          stateNxt = imAck ? SR_FETCH_IDLE : SR_FETCH_DROP;
        else if (imAck)
          stateNxt = ((DEPTH - (int'(bufCount) + int'(wrN) - (bufPop ? 1 : 0))) >= FETCH_W)
                     ? SR_FETCH_REQ : SR_FETCH_IDLE;
      end
      SR_FETCH_DROP:
        if (imAck) stateNxt = SR_FETCH_IDLE;
      default: stateNxt = SR_FETCH_IDLE;
    endcase
  end

  // State and fetch PC; a redirect overrides the line advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SR_FETCH_IDLE;
      fpc   <= {RESET_PC[31:2], 2'b00};
    end else begin
      state <= stateNxt;
      if (redirect)     fpc <= redirectPc & ~32'h3;
      else if (ackTake) fpc <= lineByte + LINE_BYTES;
    end
  end

  // Decode outputs, zeroed when nothing is valid
  always_comb begin
    instrValid = bufValid;
    instr      = bufValid ? rdEntry.instr : '0;
    instrPc    = bufValid ? rdEntry.pc    : '0;
`ifdef SR_FETCH_BYPASS_EN
    if (bypass) begin
      instrValid = 1'b1;
      instr      = imData[32*off +: 32];
      instrPc    = lineByte + 32'(4 * off);
    end
`endif
  end

endmodule
